rr_bus_arbiter: RTL and testbench

//  N-core round-robin arbiter for the single shared memory/DRAM port of the multicore SoC.
//  It muxes the granted core's request onto the shared bus and routes response data back to that core.

---
 rtl/busarb_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_rr_bus_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/busarb_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM state encoding and
// the default core state code at which a core may yield the bus.
package busarb_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_SETTLE = 2'd2,
        ST_HOLD   = 2'd3
    } arb_state_t;

    // Decode stage (S_ID) of the core pipeline.
    localparam logic [3:0] DEFAULT_IDLE_STATE = 4'h1;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after cur,
// scanning cur+1 upward and wrapping modulo N (N must be a power of two).
module rr_pick #(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] cur,
    output logic [GW-1:0] next,
    output logic          valid
);

    logic [GW-1:0] idx;

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        next  = cur;
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = N - 1; k >= 1; k--) begin
            idx = cur + GW'(k);
            if (req[idx]) begin
                next  = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter.sv
// N-core round-robin arbiter for the shared memory port; grant rotates only at a
// safe point. Optional macro BUSARB_LOCK_EN lets the granted core block preemption.
module rr_bus_arbiter
    import busarb_pkg::*;
#(
    parameter int              NCORES     = 2,
    parameter int              AW         = 32,
    parameter int              DW         = 32,
    parameter int              SW         = 4,
    parameter logic [SW-1:0]   IDLE_STATE = SW'(DEFAULT_IDLE_STATE),
    parameter int              MAX_HOLD   = 1,
    parameter int              GW         = $clog2(NCORES)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 init_done,
    input  logic [NCORES*SW-1:0] core_state,
    input  logic [NCORES-1:0]    core_req,
    input  logic [NCORES-1:0]    core_lock,
    input  logic [NCORES*AW-1:0] core_paddr,
    input  logic [NCORES*DW-1:0] core_wdata,
    input  logic [NCORES-1:0]    core_we,
    input  logic [NCORES-1:0]    core_le,
    input  logic [NCORES-1:0]    core_we_t,
    output logic [NCORES*DW-1:0] core_rdata,
    output logic [NCORES-1:0]    core_busy,
    output logic [AW-1:0]        mem_paddr,
    output logic [DW-1:0]        mem_wdata,
    output logic                 mem_we,
    output logic                 mem_le,
    output logic                 mem_we_t,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_busy,
    output logic [GW-1:0]        grant,
    output logic [NCORES-1:0]    grant_oh
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    arb_state_t    state;
    logic [7:0]    cnt;
    logic [SW-1:0] g_state;
    logic          yield_ok;
    logic          other_req;
    logic          lock_ok;
    logic          force_busy;
    logic [GW-1:0] pick_next;
    logic          pick_valid;

    always_comb begin
        mem_paddr = core_paddr[grant*AW +: AW];
        mem_wdata = core_wdata[grant*DW +: DW];
        mem_we    = core_we[grant];
        mem_le    = core_le[grant];
        mem_we_t  = core_we_t[grant];
        g_state   = core_state[grant*SW +: SW];
    end

    assign yield_ok  = (g_state == IDLE_STATE) && !mem_busy && !mem_we && !mem_le && !mem_we_t;
    assign other_req = |(core_req & ~grant_oh);

`ifdef BUSARB_LOCK_EN
    assign lock_ok = !core_lock[grant];
`else
    logic unused_lock;
    assign unused_lock = ^core_lock;
    assign lock_ok     = 1'b1;
`endif

    rr_pick #(
        .N  (NCORES),
        .GW (GW)
    ) u_pick (
        .req   (core_req),
        .cur   (grant),
        .next  (pick_next),
        .valid (pick_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_WAIT;
            grant    <= '0;
            grant_oh <= NCORES'(1);
            cnt      <= '0;
        end else if (init_done) begin
            case (state)
                ST_WAIT: begin
                    if (yield_ok && other_req && lock_ok)
                        state <= ST_SWITCH;
                end
                ST_SWITCH: begin
                    // A requester that vanished since WAIT leaves the grant in place.
                    if (pick_valid) begin
                        grant    <= pick_next;
                        grant_oh <= NCORES'(1) << pick_next;
                    end
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt   <= '0;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (cnt < HOLD_LIM)
                        cnt <= cnt + 8'd1;
                    else
                        state <= ST_WAIT;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign force_busy = (state == ST_SWITCH) || (state == ST_SETTLE);

    for (genvar i = 0; i < NCORES; i++) begin : g_route
        assign core_busy[i]            = grant_oh[i] ? (force_busy | mem_busy) : 1'b1;
        assign core_rdata[i*DW +: DW]  = grant_oh[i] ? mem_rdata : '0;
    end

`ifndef SYNTHESIS
    // A core sitting in decode must not have its bus strobes raised.
    always_ff @(posedge CLK) begin
        if (!RST && (g_state == IDLE_STATE) && (mem_we || mem_le || mem_we_t))
            $display("WARNING rr_bus_arbiter: core %0d in idle state with active bus at %0t", grant, $time);
    end
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed self-checking bench for rr_bus_arbiter with NCORES=4, MAX_HOLD=1.
module tb_rr_bus_arbiter;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam logic [3:0] IDL = 4'h1;
    localparam logic [3:0] RUN = 4'h3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              init_done;
    logic [NC*SW-1:0]  core_state;
    logic [NC-1:0]     core_req;
    logic [NC-1:0]     core_lock;
    logic [NC*AW-1:0]  core_paddr;
    logic [NC*DW-1:0]  core_wdata;
    logic [NC-1:0]     core_we;
    logic [NC-1:0]     core_le;
    logic [NC-1:0]     core_we_t;
    logic [NC*DW-1:0]  core_rdata;
    logic [NC-1:0]     core_busy;
    logic [AW-1:0]     mem_paddr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic              mem_le;
    logic              mem_we_t;
    logic [DW-1:0]     mem_rdata;
    logic              mem_busy;
    logic [1:0]        grant;
    logic [NC-1:0]     grant_oh;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    rr_bus_arbiter #(
        .NCORES     (NC),
        .AW         (AW),
        .DW         (DW),
        .SW         (SW),
        .IDLE_STATE (IDL),
        .MAX_HOLD   (1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .init_done  (init_done),
        .core_state (core_state),
        .core_req   (core_req),
        .core_lock  (core_lock),
        .core_paddr (core_paddr),
        .core_wdata (core_wdata),
        .core_we    (core_we),
        .core_le    (core_le),
        .core_we_t  (core_we_t),
        .core_rdata (core_rdata),
        .core_busy  (core_busy),
        .mem_paddr  (mem_paddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_le     (mem_le),
        .mem_we_t   (mem_we_t),
        .mem_rdata  (mem_rdata),
        .mem_busy   (mem_busy),
        .grant      (grant),
        .grant_oh   (grant_oh)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_st(input int i, input logic [3:0] v);
        core_state[i*SW +: SW] = v;
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        init_done  = 1'b1;
        core_state = {RUN, RUN, RUN, RUN};
        core_req   = '0;
        core_lock  = '0;
        core_we    = '0;
        core_le    = '0;
        core_we_t  = '0;
        mem_busy   = 1'b0;
        mem_rdata  = '0;
        tick(2);
        RST = 1'b0;
    endtask

    function automatic logic [127:0] st();
        return 128'(dut.state);
    endfunction

    initial begin
        core_paddr = {32'h0000_00D3, 32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
        core_wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};

        // Reset state
        do_reset();
        chk("rst_grant", 128'(grant), 128'd0);
        chk("rst_grant_oh", 128'(grant_oh), 128'b0001);
        chk("rst_state", st(), 128'd0);
        chk("rst_busy", 128'(core_busy), 128'b1110);
        chk("rst_paddr", 128'(mem_paddr), 128'h0000_00A0);

        // 1: req 1110, core 0 yields -> grant 1, HOLD lasts 2 cycles
        core_req  = 4'b1110;
        mem_rdata = 32'h5555_AAAA;
        set_st(0, IDL);
        tick(1);
        chk("t1_switch_state", st(), 128'd1);
        chk("t1_switch_grant", 128'(grant), 128'd0);
        chk("t1_switch_busy", 128'(core_busy), 128'b1111);
        tick(1);
        chk("t1_settle_state", st(), 128'd2);
        chk("t1_settle_grant", 128'(grant), 128'd1);
        chk("t1_settle_oh", 128'(grant_oh), 128'b0010);
        chk("t1_settle_busy", 128'(core_busy), 128'b1111);
        tick(1);
        chk("t1_hold1_state", st(), 128'd3);
        chk("t1_hold1_busy", 128'(core_busy), 128'b1101);
        tick(1);
        chk("t1_hold2_state", st(), 128'd3);
        tick(1);
        chk("t1_wait_state", st(), 128'd0);
        chk("t1_paddr", 128'(mem_paddr), 128'h0000_00B1);
        chk("t1_wdata", 128'(mem_wdata), 128'h1111_1111);
        chk("t1_rdata", 128'(core_rdata), {64'd0, 32'h5555_AAAA, 32'd0});

        // 2: req 1001 from grant 0 -> 3, then wrap to 0; init_done freezes first
        do_reset();
        init_done = 1'b0;
        core_req  = 4'b1001;
        set_st(0, IDL);
        tick(3);
        chk("t2_frozen_state", st(), 128'd0);
        chk("t2_frozen_grant", 128'(grant), 128'd0);
        init_done = 1'b1;
        tick(2);
        chk("t2_grant3", 128'(grant), 128'd3);
        tick(3);
        chk("t2_wait_state", st(), 128'd0);
        set_st(3, IDL);
        tick(2);
        chk("t2_wrap_grant", 128'(grant), 128'd0);
        chk("t2_wrap_oh", 128'(grant_oh), 128'b0001);

        // 3: only core 0 requests -> no rotation
        do_reset();
        core_req = 4'b0001;
        set_st(0, IDL);
        mem_busy = 1'b1;
        tick(4);
        chk("t3_state", st(), 128'd0);
        chk("t3_grant", 128'(grant), 128'd0);
        chk("t3_busy_hi", 128'(core_busy), 128'b1111);
        mem_busy = 1'b0;
        #1;
        chk("t3_busy_lo", 128'(core_busy), 128'b1110);
        tick(3);
        chk("t3_grant_late", 128'(grant), 128'd0);

        // 4: idle but mem_busy holds the switch off
        do_reset();
        core_req  = 4'b0011;
        set_st(0, IDL);
        mem_busy  = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick(3);
        chk("t4_state", st(), 128'd0);
        chk("t4_grant", 128'(grant), 128'd0);
        chk("t4_rdata0", 128'(core_rdata), {96'd0, 32'hCAFE_F00D});
        mem_busy = 1'b0;
        tick(1);
        chk("t4_switch", st(), 128'd1);
        tick(1);
        chk("t4_grant1", 128'(grant), 128'd1);
        chk("t4_rdata1", 128'(core_rdata), {64'd0, 32'hCAFE_F00D, 32'd0});

        // 5: lock on the granted core
        do_reset();
        core_req = 4'b0010;
        set_st(0, IDL);
        tick(5);
        chk("t5_grant1", 128'(grant), 128'd1);
        core_lock = 4'b0010;
        core_req  = 4'b0110;
        set_st(1, IDL);
`ifdef BUSARB_LOCK_EN
        tick(20);
        chk("t5_locked_grant", 128'(grant), 128'd1);
        chk("t5_locked_state", st(), 128'd0);
        core_lock = '0;
        tick(2);
        chk("t5_release_grant", 128'(grant), 128'd2);
`else
        tick(2);
        chk("t5_nolock_grant", 128'(grant), 128'd2);
`endif

        // 6: asynchronous reset during HOLD with grant 2
        do_reset();
        core_req = 4'b0100;
        set_st(0, IDL);
        tick(3);
        chk("t6_hold_state", st(), 128'd3);
        chk("t6_hold_grant", 128'(grant), 128'd2);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_async_grant", 128'(grant), 128'd0);
        chk("t6_async_oh", 128'(grant_oh), 128'b0001);
        chk("t6_async_state", st(), 128'd0);
        chk("t6_async_busy", 128'(core_busy), 128'b1110);
        tick(1);
        RST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
